// File: rtl/skew_feeder_pkg.sv
// Shared definitions for the skew feeder: FSM state encoding, the default
// lane width, and the shift-register address width helper.
package skew_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int LANE_DW = 16;

  // Tap addresses run 1..N, so the address must be able to hold N.
  function automatic int addr_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dynamic_shreg.sv
// Addressable shift register: on ce the word at d enters stage 0; q taps the
// word that entered addr shifts ago (addr 0 passes d straight through).
module dynamic_shreg #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          ce,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // NOTE: the storage has no reset on purpose; consumers mask stale words
  // with their own resettable valid bits, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (ce) begin
      mem[0] <= d;
      for (int i = DEPTH - 1; i > 0; i--) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign q = (addr == '0) ? d : mem[addr - 1'b1];

endmodule

// File: rtl/skew_feeder.sv
// Diagonal skew feeder for a systolic array: lane k of each input column is
// delayed k beats, and trailing columns are drained with zero-filled lanes.
module skew_feeder
  import skew_feeder_pkg::*;
#(
  parameter int DW = LANE_DW,
  parameter int N  = 4,
  parameter int LW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [LW-1:0]   len,
  input  logic [N*DW-1:0] din,
  input  logic            din_vld,
  output logic            din_rdy,
  output logic [N*DW-1:0] dout,
  output logic [N-1:0]    dout_vld,
  output logic            col_vld,
  output logic            busy,
  output logic            done
);

  localparam int AW = addr_width(N);
  localparam logic [AW-1:0] DRAIN_LAST = AW'(N > 1 ? N - 2 : 0);

  state_t        state;
  logic [LW-1:0] len_r;
  logic [LW-1:0] beat_cnt;
  logic [AW-1:0] drain_cnt;
  logic [N-1:0]  vp;
  logic          shift;
  logic [DW-1:0] tap [N];

  assign shift    = ((state == LOAD) && din_vld) || (state == DRAIN);
  assign din_rdy  = (state == LOAD);
  assign busy     = (state != IDLE);
  assign dout_vld = vp;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len_r     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      vp        <= '0;
      col_vld   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done    <= 1'b0;
      col_vld <= shift;

      if (shift) begin
        vp[0] <= (state == LOAD);
        for (int k = N - 1; k > 0; k--) begin
          vp[k] <= vp[k-1];
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              state    <= LOAD;
              len_r    <= len;
              beat_cnt <= '0;
            end
          end
        end

        LOAD: begin
          if (din_vld) begin
            // len_r is never zero here, so the compare cannot underflow.
            if (beat_cnt == len_r - 1'b1) begin
              beat_cnt <= '0;
              if (N == 1) begin
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                state     <= DRAIN;
                drain_cnt <= '0;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state     <= IDLE;
            drain_cnt <= '0;
            done      <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [DW-1:0] lane_in;

    // Drain cycles push zeros so the trailing edge of the wavefront is clean.
    assign lane_in = (state == LOAD) ? din[k*DW +: DW] : '0;

    dynamic_shreg #(
      .DW (DW),
      .AW (AW)
    ) u_shreg (
      .clk  (clk),
      .ce   (shift),
      .addr (AW'(k + 1)),
      .d    (lane_in),
      .q    (tap[k])
    );

    assign dout[k*DW +: DW] = vp[k] ? tap[k] : '0;
  end

endmodule
